// File: rtl/mmu_sequencer.sv
// Job sequencer for the systolic MMU: clear, weight load, vector feed, drain.
// Optional PERF_CYCLES/PERF_STALLS counters are built when MMU_SEQUENCER_PERF_CNT_EN is defined.
module mmu_sequencer #(
  parameter int SA_LENGTH      = 256,
  parameter int ADDR_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int RESULT_LATENCY = 512
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] WEIGHT_BASE,
  input  logic [ADDR_WIDTH-1:0] INPUT_BASE,
  input  logic [ADDR_WIDTH-1:0] ACC_BASE,
  input  logic [CNT_WIDTH-1:0]  NUM_VECS,
  input  logic                  STALL,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MMU_EN,
  output logic                  MMU_LOAD,
  output logic                  MMU_SYNC_RST,
  output logic                  WBUF_RD_EN,
  output logic [ADDR_WIDTH-1:0] WBUF_RD_ADDR,
  output logic                  IBUF_RD_EN,
  output logic [ADDR_WIDTH-1:0] IBUF_RD_ADDR,
  output logic                  ACC_WR_EN,
  output logic [ADDR_WIDTH-1:0] ACC_WR_ADDR
`ifdef MMU_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0]           PERF_CYCLES,
  output logic [31:0]           PERF_STALLS
`endif
);

  localparam int IW = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_W = 3'd2,
    S_FEED   = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [ADDR_WIDTH-1:0]     wbase_r;
  logic [ADDR_WIDTH-1:0]     ibase_r;
  logic [ADDR_WIDTH-1:0]     abase_r;
  logic [CNT_WIDTH-1:0]      num_r;
  logic [IW-1:0]             i_r;
  logic [CNT_WIDTH-1:0]      k_r;
  logic [CNT_WIDTH-1:0]      w_r;
  logic                      load_r;
  logic [RESULT_LATENCY-1:0] dl_r;

  logic run_s;
  logic wbuf_en_s;
  logic ibuf_en_s;
  logic acc_en_s;
  logic last_w_s;
  logic last_k_s;
  logic drained_s;
  logic accept_s;

  // Enable qualification and strobe generation; STALL masks strobes in the same cycle
  always_comb begin
    run_s     = 1'b0;
    wbuf_en_s = 1'b0;
    ibuf_en_s = 1'b0;
    acc_en_s  = 1'b0;
    if ((state_r == S_LOAD_W) || (state_r == S_FEED) || (state_r == S_DRAIN)) begin
      run_s = ~STALL;
    end else begin
      run_s = 1'b0;
    end
    wbuf_en_s = run_s & (state_r == S_LOAD_W);
    ibuf_en_s = run_s & (state_r == S_FEED);
    acc_en_s  = run_s & dl_r[RESULT_LATENCY-1];
    last_w_s  = (i_r == IW'(SA_LENGTH - 1));
    last_k_s  = (k_r == (num_r - CNT_WIDTH'(1)));
    drained_s = (dl_r == '0) && (w_r == num_r);
    accept_s  = (state_r == S_IDLE) && START;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) state_s = S_CLEAR;
        else       state_s = S_IDLE;
      end
      S_CLEAR: state_s = S_LOAD_W;
      S_LOAD_W: begin
        if (run_s && last_w_s) state_s = (num_r == '0) ? S_DRAIN : S_FEED;
        else                   state_s = S_LOAD_W;
      end
      S_FEED: begin
        if (run_s && last_k_s) state_s = S_DRAIN;
        else                   state_s = S_FEED;
      end
      S_DRAIN: begin
        if (run_s && drained_s) state_s = S_FIN;
        else                    state_s = S_DRAIN;
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) state_r <= S_IDLE;
    else            state_r <= state_s;
  end

  // Job parameters, counters and result delay line; all frozen on stalled cycles
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      wbase_r <= '0;
      ibase_r <= '0;
      abase_r <= '0;
      num_r   <= '0;
      i_r     <= '0;
      k_r     <= '0;
      w_r     <= '0;
      load_r  <= 1'b0;
      dl_r    <= '0;
    end else if (accept_s) begin
      wbase_r <= WEIGHT_BASE;
      ibase_r <= INPUT_BASE;
      abase_r <= ACC_BASE;
      num_r   <= NUM_VECS;
      i_r     <= '0;
      k_r     <= '0;
      w_r     <= '0;
      load_r  <= 1'b0;
      dl_r    <= '0;
    end else if (run_s) begin
      load_r <= wbuf_en_s;
      dl_r   <= {dl_r[RESULT_LATENCY-2:0], ibuf_en_s};
      if (wbuf_en_s) i_r <= i_r + IW'(1);
      if (ibuf_en_s) k_r <= k_r + CNT_WIDTH'(1);
      if (acc_en_s)  w_r <= w_r + CNT_WIDTH'(1);
    end
  end

  // Output drive; addresses read as zero whenever their strobe is low
  always_comb begin
    BUSY         = (state_r != S_IDLE);
    DONE         = (state_r == S_FIN);
    MMU_EN       = run_s;
    MMU_SYNC_RST = (state_r == S_CLEAR);
    MMU_LOAD     = run_s & load_r;
    WBUF_RD_EN   = wbuf_en_s;
    IBUF_RD_EN   = ibuf_en_s;
    ACC_WR_EN    = acc_en_s;
    WBUF_RD_ADDR = wbuf_en_s ? (wbase_r + ADDR_WIDTH'(i_r)) : '0;
    IBUF_RD_ADDR = ibuf_en_s ? (ibase_r + ADDR_WIDTH'(k_r)) : '0;
    ACC_WR_ADDR  = acc_en_s  ? (abase_r + ADDR_WIDTH'(w_r)) : '0;
  end

`ifdef MMU_SEQUENCER_PERF_CNT_EN
  logic [31:0] cyc_r;
  logic [31:0] stl_r;

  // Saturating job cycle and stall counters, cleared on each accepted job
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      cyc_r <= 32'd0;
      stl_r <= 32'd0;
    end else if (accept_s) begin
      cyc_r <= 32'd0;
      stl_r <= 32'd0;
    end else begin
      if ((state_r != S_IDLE) && (cyc_r != 32'hFFFF_FFFF)) cyc_r <= cyc_r + 32'd1;
      if (STALL && (stl_r != 32'hFFFF_FFFF) &&
          ((state_r == S_LOAD_W) || (state_r == S_FEED) || (state_r == S_DRAIN)))
        stl_r <= stl_r + 32'd1;
    end
  end

  assign PERF_CYCLES = cyc_r;
  assign PERF_STALLS = stl_r;
`endif

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed, table-driven bench for mmu_sequencer (SA_LENGTH=4, ADDR_WIDTH=8, RESULT_LATENCY=6).
module tb_mmu_sequencer;

  logic       CLK = 1'b0;
  logic       ASYNC_RST;
  logic       START;
  logic [7:0] WEIGHT_BASE;
  logic [7:0] INPUT_BASE;
  logic [7:0] ACC_BASE;
  logic [7:0] NUM_VECS;
  logic       STALL;
  logic       BUSY, DONE, MMU_EN, MMU_LOAD, MMU_SYNC_RST;
  logic       WBUF_RD_EN, IBUF_RD_EN, ACC_WR_EN;
  logic [7:0] WBUF_RD_ADDR, IBUF_RD_ADDR, ACC_WR_ADDR;
`ifdef MMU_SEQUENCER_PERF_CNT_EN
  logic [31:0] PERF_CYCLES, PERF_STALLS;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] outs_s;
  assign outs_s = {BUSY, DONE, MMU_EN, MMU_LOAD, MMU_SYNC_RST, WBUF_RD_EN, IBUF_RD_EN,
                   ACC_WR_EN, WBUF_RD_ADDR, IBUF_RD_ADDR, ACC_WR_ADDR};

  mmu_sequencer #(
    .SA_LENGTH(4), .ADDR_WIDTH(8), .CNT_WIDTH(8), .RESULT_LATENCY(6)
  ) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .START(START),
    .WEIGHT_BASE(WEIGHT_BASE), .INPUT_BASE(INPUT_BASE), .ACC_BASE(ACC_BASE),
    .NUM_VECS(NUM_VECS), .STALL(STALL),
    .BUSY(BUSY), .DONE(DONE), .MMU_EN(MMU_EN), .MMU_LOAD(MMU_LOAD),
    .MMU_SYNC_RST(MMU_SYNC_RST),
    .WBUF_RD_EN(WBUF_RD_EN), .WBUF_RD_ADDR(WBUF_RD_ADDR),
    .IBUF_RD_EN(IBUF_RD_EN), .IBUF_RD_ADDR(IBUF_RD_ADDR),
    .ACC_WR_EN(ACC_WR_EN), .ACC_WR_ADDR(ACC_WR_ADDR)
`ifdef MMU_SEQUENCER_PERF_CNT_EN
    , .PERF_CYCLES(PERF_CYCLES), .PERF_STALLS(PERF_STALLS)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  wbase;
    logic [7:0]  ibase;
    logic [7:0]  abase;
    logic [7:0]  nv;
    logic [63:0] stall_mask;  // bit c = STALL during cycle c (cycle 0 carries START)
    int          start2;      // cycle of an extra START pulse while busy, 0 = none
    int          exp_done;    // cycle index of the DONE pulse
    int          exp_stalls;  // stalled cycles inside LOAD_W/FEED/DRAIN
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input int id, input vec_t v);
    int wq[$], wc[$], iq[$], ic[$], aq[$], ac[$], lc[$];
    int nsync, sync_c, ndone, done_c, nbusy;
    nsync = 0; sync_c = -1; ndone = 0; done_c = -1; nbusy = 0;
    for (int c = 0; c < 48; c++) begin
      START = (c == 0) || ((v.start2 != 0) && (c == v.start2));
      if (c == 0) begin
        WEIGHT_BASE = v.wbase; INPUT_BASE = v.ibase; ACC_BASE = v.abase; NUM_VECS = v.nv;
      end else if (c == v.start2) begin
        WEIGHT_BASE = 8'hAA; INPUT_BASE = 8'hAA; ACC_BASE = 8'hAA; NUM_VECS = 8'd7;
      end
      STALL = v.stall_mask[c];
      @(negedge CLK);
      if (c == 0) check($sformatf("v%0d_busy_c0", id), 32'(BUSY), 32'd0);
      if (WBUF_RD_EN) begin wq.push_back(int'(WBUF_RD_ADDR)); wc.push_back(c); end
      if (IBUF_RD_EN) begin iq.push_back(int'(IBUF_RD_ADDR)); ic.push_back(c); end
      if (ACC_WR_EN)  begin aq.push_back(int'(ACC_WR_ADDR));  ac.push_back(c); end
      if (MMU_LOAD) lc.push_back(c);
      if (MMU_SYNC_RST) begin nsync++; sync_c = c; end
      if (DONE) begin ndone++; done_c = c; end
      if (BUSY) nbusy++;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    STALL = 1'b0;

    check($sformatf("v%0d_sync_cnt", id), nsync, 1);
    check($sformatf("v%0d_sync_cyc", id), sync_c, 1);
    check($sformatf("v%0d_wbuf_cnt", id), wq.size(), 4);
    check($sformatf("v%0d_load_cnt", id), lc.size(), 4);
    check($sformatf("v%0d_ibuf_cnt", id), iq.size(), int'(v.nv));
    check($sformatf("v%0d_acc_cnt", id), aq.size(), int'(v.nv));
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size())
        check($sformatf("v%0d_waddr%0d", id, i), wq[i], (int'(v.wbase) + i) & 255);
    end
    for (int k = 0; k < int'(v.nv); k++) begin
      if (k < iq.size())
        check($sformatf("v%0d_iaddr%0d", id, k), iq[k], (int'(v.ibase) + k) & 255);
      if (k < aq.size())
        check($sformatf("v%0d_aaddr%0d", id, k), aq[k], (int'(v.abase) + k) & 255);
    end
    if (v.stall_mask == 64'd0) begin
      for (int i = 0; i < 4; i++) begin
        if ((i < lc.size()) && (i < wc.size()))
          check($sformatf("v%0d_load_lat%0d", id, i), lc[i] - wc[i], 1);
      end
      for (int k = 0; k < int'(v.nv); k++) begin
        if ((k < ac.size()) && (k < ic.size()))
          check($sformatf("v%0d_acc_lat%0d", id, k), ac[k] - ic[k], 6);
      end
    end
    check($sformatf("v%0d_done_cnt", id), ndone, 1);
    check($sformatf("v%0d_done_cyc", id), done_c, v.exp_done);
    check($sformatf("v%0d_busy_cycles", id), nbusy, v.exp_done);
`ifdef MMU_SEQUENCER_PERF_CNT_EN
    check($sformatf("v%0d_perf_cycles", id), PERF_CYCLES, v.exp_done);
    check($sformatf("v%0d_perf_stalls", id), PERF_STALLS, v.exp_stalls);
`endif
  endtask

  initial begin
    int ndone, nbusy;
    //          wbase  ibase  abase  nv     stall_mask      start2 done stalls
    vecs[0] = '{8'h10, 8'h40, 8'h80, 8'd3, 64'h0,            0,   16,  0};
    vecs[1] = '{8'h10, 8'h40, 8'h80, 8'd3, 64'h0000_0C3B,    0,   21,  5};
    vecs[2] = '{8'h20, 8'h50, 8'h90, 8'd0, 64'h0,            0,    7,  0};
    vecs[3] = '{8'hFE, 8'hFD, 8'hFE, 8'd3, 64'h0,            0,   16,  0};
    vecs[4] = '{8'h00, 8'h7F, 8'h01, 8'd1, 64'h0,            0,   14,  0};
    vecs[5] = '{8'h10, 8'h40, 8'h80, 8'd3, 64'h0,            7,   16,  0};
    vecs[6] = '{8'h30, 8'h60, 8'hA0, 8'd3, 64'h0000_6000,    0,   18,  2};

    ASYNC_RST = 1'b0; START = 1'b0; STALL = 1'b0;
    WEIGHT_BASE = 8'h00; INPUT_BASE = 8'h00; ACC_BASE = 8'h00; NUM_VECS = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outs", outs_s, 32'd0);
`ifdef MMU_SEQUENCER_PERF_CNT_EN
    check("reset_perf_cycles", PERF_CYCLES, 32'd0);
`endif
    ASYNC_RST = 1'b1;
    @(posedge CLK); #1;
    check("idle_outs", outs_s, 32'd0);

    for (int n = 0; n < 7; n++) run_job(n, vecs[n]);

    // Asynchronous reset in the middle of FEED aborts the job without DONE
    START = 1'b1; STALL = 1'b0;
    WEIGHT_BASE = 8'h10; INPUT_BASE = 8'h40; ACC_BASE = 8'h80; NUM_VECS = 8'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("rst_pre_ibuf_en", 32'(IBUF_RD_EN), 32'd1);
    check("rst_pre_ibuf_addr", 32'(IBUF_RD_ADDR), 32'h41);
    ASYNC_RST = 1'b0;
    #1;
    check("rst_mid_feed_outs", outs_s, 32'd0);
    ndone = 0; nbusy = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (DONE) ndone++;
      if (BUSY) nbusy++;
    end
    check("rst_no_done", ndone, 0);
    check("rst_no_busy", nbusy, 0);
    @(posedge CLK); #1;
    run_job(7, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
